// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/PC-hold generator for load-use, redirect, MAC occupancy and dmem wait.
// Optional MAC sequencing built only when PIPE_MAC_HAZARD_EN is defined.
module pipe_hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int MAC_LAT      = 4,
  parameter int CNT_W        = 4,
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_ID,
  input  logic [ADDR_W-1:0] rs2_ID,
  input  logic [ADDR_W-1:0] rd_EX,
  input  logic              memread_EX,
  input  logic              mac_start_EX,
  input  logic              redirect_MEM,
  input  logic              dmem_wait,
  output logic              pc_hold,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_MEM,
  output logic              stall_MEM_WB,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              mac_busy,
  output logic              timeout_err
);
  logic            load_use, mac_hold, in_run, terr;
  logic [TO_W-1:0] wd;
  assign load_use = memread_EX && rd_EX != '0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
`ifdef PIPE_MAC_HAZARD_EN
  typedef enum logic {RUN, MAC_BUSY} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // Freeze cycles leave state and cnt untouched so the MAC sequence stretches one-for-one.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!dmem_wait) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mac_hold = 1'b0;
    if (state == RUN) begin
      if (mac_start_EX && !redirect_MEM) begin
        state_n  = MAC_BUSY;
        cnt_n    = CNT_W'(MAC_LAT - 2);
        mac_hold = 1'b1;
      end
    end else if (cnt != '0) begin
      cnt_n    = cnt - 1'b1;
      mac_hold = 1'b1;
    end else begin
      state_n = RUN;
    end
  end
  assign in_run = state == RUN;
`else
  logic [CNT_W-1:0] unused_mac;
  assign unused_mac = CNT_W'(MAC_LAT) ^ {CNT_W{mac_start_EX}};
  assign mac_hold   = 1'b0;
  assign in_run     = 1'b1;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wd   <= '0;
      terr <= 1'b0;
    end else if (dmem_wait) begin
      wd   <= (wd == TO_W'(WAIT_TIMEOUT)) ? wd : wd + 1'b1;
      terr <= terr | (wd >= TO_W'(WAIT_TIMEOUT - 1));
    end else begin
      wd   <= '0;
    end
  always_comb begin
    pc_hold      = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    if (reset) begin
    end else if (dmem_wait) begin
      pc_hold      = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
    end else if (in_run && redirect_MEM) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
    end else if (mac_hold) begin
      pc_hold      = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
    end else if (in_run && load_use) begin
      pc_hold      = 1'b1;
      stall_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
    end
  end
  assign mac_busy    = !reset && !in_run;
  assign timeout_err = !reset && terr;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard checked at the falling edge.
module tb_pipe_hazard_ctrl;
  localparam bit M = `ifdef PIPE_MAC_HAZARD_EN 1'b1 `else 1'b0 `endif;
  localparam logic [9:0] Z   = 10'b00000_000_00;
  localparam logic [9:0] FRZ = 10'b11111_000_00;
  localparam logic [9:0] LU  = 10'b11000_010_00;
  localparam logic [9:0] RD  = 10'b00000_111_00;
  localparam logic [9:0] MH  = 10'b11100_001_00;
  localparam logic [9:0] B   = 10'b00000_000_10;
  localparam logic [9:0] T   = 10'b00000_000_01;

  logic clock = 1'b0, reset = 1'b1;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
  logic memread_EX = 1'b0, mac_start_EX = 1'b0, redirect_MEM = 1'b0, dmem_wait = 1'b0;
  logic pc_hold, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, mac_busy, timeout_err;

  typedef struct {
    logic [9:0] e;
    string      n;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  pipe_hazard_ctrl #(.ADDR_W(5), .MAC_LAT(4), .CNT_W(4), .WAIT_TIMEOUT(8), .TO_W(4)) dut (
    .clock(clock), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX),
    .memread_EX(memread_EX), .mac_start_EX(mac_start_EX), .redirect_MEM(redirect_MEM),
    .dmem_wait(dmem_wait), .pc_hold(pc_hold), .stall_IF_ID(stall_IF_ID),
    .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .mac_busy(mac_busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (sb.size() > 0) begin
      exp_t x;
      logic [9:0] a;
      x = sb.pop_front();
      a = {pc_hold, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, mac_busy, timeout_err};
      n_chk++;
      if (a !== x.e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", x.n, a, x.e);
      end
    end

  task automatic cyc(input string nm, input logic r, w, rdr, mac, mr,
                     input logic [4:0] rd, r1, r2, input logic [9:0] e);
    @(posedge clock);
    #1;
    reset = r; dmem_wait = w; redirect_MEM = rdr; mac_start_EX = mac;
    memread_EX = mr; rd_EX = rd; rs1_ID = r1; rs2_ID = r2;
    sb.push_back('{e, nm});
  endtask

  initial begin
    cyc("reset",      1, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("idle",       0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("lu_rs2",     0, 0, 0, 0, 1, 5, 0, 5, LU);
    cyc("lu_drop",    0, 0, 0, 0, 0, 5, 0, 5, Z);
    cyc("lu_rs1",     0, 0, 0, 0, 1, 7, 7, 3, LU);
    cyc("lu_x0",      0, 0, 0, 0, 1, 0, 0, 0, Z);
    cyc("lu_noload",  0, 0, 0, 0, 0, 5, 5, 5, Z);
    cyc("lu_nomatch", 0, 0, 0, 0, 1, 4, 5, 6, Z);
    cyc("mac0",       0, 0, 0, 1, 1, 5, 5, 0, M ? MH : LU);
    cyc("mac1",       0, 0, 0, 1, 1, 5, 5, 0, M ? (MH | B) : LU);
    cyc("mac2",       0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("mac3_rel",   0, 0, 0, 1, 0, 0, 0, 0, M ? B : Z);
    cyc("mac4",       0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("fm0",        0, 0, 0, 1, 0, 0, 0, 0, M ? MH : Z);
    cyc("fm1_frz",    0, 1, 0, 1, 0, 0, 0, 0, FRZ | (M ? B : Z));
    cyc("fm2_frz",    0, 1, 0, 1, 0, 0, 0, 0, FRZ | (M ? B : Z));
    cyc("fm3",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("fm4",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("fm5_rel",    0, 0, 0, 1, 0, 0, 0, 0, M ? B : Z);
    cyc("fm6",        0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("rd_mac",     0, 0, 1, 1, 0, 0, 0, 0, RD);
    cyc("rd_next",    0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("rd_lu",      0, 0, 1, 0, 1, 5, 5, 0, RD);
    cyc("frz_rd",     0, 1, 1, 0, 0, 0, 0, 0, FRZ);
    cyc("idle2",      0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("ri0",        0, 0, 0, 1, 0, 0, 0, 0, M ? MH : Z);
    cyc("ri1",        0, 0, 1, 1, 0, 0, 0, 0, M ? (MH | B) : RD);
    cyc("ri2",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("ri3",        0, 0, 0, 1, 0, 0, 0, 0, M ? B : Z);
    cyc("ri4",        0, 0, 0, 0, 0, 0, 0, 0, Z);
    for (int i = 0; i < 7; i++) cyc("wd7", 0, 1, 0, 0, 0, 0, 0, 0, FRZ);
    cyc("wd7_after",  0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("wd7_idle",   0, 0, 0, 0, 0, 0, 0, 0, Z);
    for (int i = 0; i < 8; i++) cyc("wd8", 0, 1, 0, 0, 0, 0, 0, 0, FRZ);
    cyc("wd8_set",    0, 0, 0, 0, 0, 0, 0, 0, T);
    cyc("wd_frz_t",   0, 1, 0, 0, 0, 0, 0, 0, FRZ | T);
    cyc("wd_sticky",  0, 0, 0, 0, 1, 3, 3, 0, LU | T);
    cyc("rm0",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | T) : T);
    cyc("rm1_rst",    1, 0, 0, 1, 1, 5, 5, 5, Z);
    cyc("rm2_rst",    1, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("rm3",        0, 0, 0, 0, 0, 0, 0, 0, Z);
    cyc("rm4",        0, 0, 0, 1, 0, 0, 0, 0, M ? MH : Z);
    cyc("rm5",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("rm6",        0, 0, 0, 1, 0, 0, 0, 0, M ? (MH | B) : Z);
    cyc("rm7",        0, 0, 0, 1, 0, 0, 0, 0, M ? B : Z);
    cyc("rm8",        0, 0, 0, 0, 0, 0, 0, 0, Z);
    repeat (3) @(negedge clock);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
